muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: one shift-add or restoring
// shift-subtract step per clock on operand magnitudes, sign fixed up at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  logic [2:0]       op_q;
  logic             neg_q, rneg_q;
  logic [WIDTH-1:0] opnd_q, hi_q, lo_q;

  logic             a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf, accept;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  // Operand decode: which operands are signed, and their magnitudes.
  always_comb begin
    a_sgn  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
             (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg  = a_sgn & a[WIDTH-1];
    b_neg  = b_sgn & b[WIDTH-1];
    a_mag  = cond_neg(a, a_neg);
    b_mag  = cond_neg(b, b_neg);
    is_div = funct3[2];
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && !funct3[0] && (a == MOST_NEG) && (b == '1);
    accept   = (state_q == S_IDLE) && start && !kill;
    if (div_zero)
      special_res = funct3[1] ? a : '1;
    else
      special_res = funct3[1] ? '0 : a;
  end

  logic [WIDTH:0]     shifted, diff, mul_sum;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

  // One iteration: hi_q holds the partial product / running remainder,
  // lo_q the multiplier being consumed / quotient being built.
  always_comb begin
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    if (op_q[2]) begin
      if (!diff[WIDTH]) begin
        step_hi = diff[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shifted[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = cond_neg2({hi_q, lo_q}, neg_q);
    quo_fix  = cond_neg(lo_q, neg_q);
    rem_fix  = cond_neg(hi_q, rneg_q);
    if (op_q[2])
      final_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00)
      final_res = prod_fix[WIDTH-1:0];
    else
      final_res = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (div_zero || div_ovf) begin
            result_d = special_res;
            valid_d  = 1'b1;
          end else begin
            state_d = S_CALC;
            cnt_d   = '0;
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!kill) begin
          result_d = final_res;
          valid_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= funct3;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      hi_q   <= '0;
      opnd_q <= is_div ? b_mag : a_mag;
      lo_q   <= is_div ? a_mag : b_mag;
    end else if (state_q == S_CALC) begin
      hi_q <= step_hi;
      lo_q <= step_lo;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: vector table plus kill,
// back-to-back, busy-start and mid-operation reset sequences.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         kill;
  logic [2:0]   funct3;
  logic [W-1:0] a, b;
  logic         ready, busy, valid;
  logic [W-1:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    bit           sp;
    string        nm;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request, take edge E0, then scramble the operand inputs.
  task automatic launch(input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    start  = 1'b1;
    funct3 = f;
    a      = av;
    b      = bv;
    tick();
    start  = 1'b0;
    funct3 = 3'($urandom);
    a      = $urandom;
    b      = $urandom;
  endtask

  // Called in the cycle after E0 (k0 edges later); stops in the valid cycle.
  task automatic await_op(input logic [W-1:0] exp, input bit sp, input string nm, input int k0);
    int k;
    int busy_n;
    k = k0;
    busy_n = k0;
    while (!valid && k < 60) begin
      if (busy) busy_n++;
      tick();
      k++;
    end
    chk({nm, " valid"}, 64'(valid), 64'd1);
    chk({nm, " latency"}, 64'(k), sp ? 64'd0 : 64'd33);
    chk({nm, " busy cycles"}, 64'(busy_n), sp ? 64'd0 : 64'd33);
    chk({nm, " result"}, 64'(result), 64'(exp));
    chk({nm, " ready in valid cycle"}, 64'(ready), 64'd1);
  endtask

  initial begin
    vt[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "MUL 7*-3"};
    vt[1]  = '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 1'b0, "MULH min*min"};
    vt[2]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "MULHU max*max"};
    vt[3]  = '{3'b010, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 1'b0, "MULHSU -1*2"};
    vt[4]  = '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0, "DIV -7/2"};
    vt[5]  = '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1'b0, "REM -7/2"};
    vt[6]  = '{3'b101, 32'd100,        32'd7,        32'd14,       1'b0, "DIVU 100/7"};
    vt[7]  = '{3'b111, 32'd100,        32'd7,        32'd2,        1'b0, "REMU 100/7"};
    vt[8]  = '{3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1'b1, "DIV 5/0"};
    vt[9]  = '{3'b111, 32'd5,          32'd0,        32'd5,        1'b1, "REMU 5/0"};
    vt[10] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1, "DIV ovf"};
    vt[11] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1'b1, "REM ovf"};
    vt[12] = '{3'b000, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        1'b0, "MUL -1*-1"};
    vt[13] = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        1'b0, "MULH -1*-1"};
    vt[14] = '{3'b011, 32'hFFFFFFFF,   32'd2,        32'd1,        1'b0, "MULHU max*2"};
    vt[15] = '{3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        1'b0, "REM 7/-2"};
    vt[16] = '{3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "DIV 7/-2"};
    vt[17] = '{3'b101, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 1'b0, "DIVU max/1"};
    vt[18] = '{3'b101, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1'b0, "DIVU min/max"};
    vt[19] = '{3'b111, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b0, "REMU min/max"};

    reset  = 1'b0;
    start  = 1'b1;
    kill   = 1'b0;
    funct3 = 3'b000;
    a      = 32'd3;
    b      = 32'd5;
    #12;
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset valid", 64'(valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);

    // Release between edges with start already high: next edge accepts.
    @(negedge clk);
    reset = 1'b1;
    tick();
    start = 1'b0;
    chk("first start accepted", 64'(busy), 64'd1);
    await_op(32'd15, 1'b0, "MUL 3*5 after reset", 0);
    tick();

    for (int i = 0; i < 20; i++) begin
      launch(vt[i].f, vt[i].a, vt[i].b);
      await_op(vt[i].exp, vt[i].sp, vt[i].nm, 0);
      tick();
      chk({vt[i].nm, " valid one cycle"}, 64'(valid), 64'd0);
    end

    // Kill at iteration 10: no completion, result keeps last value.
    begin
      int seen;
      seen = 0;
      launch(3'b000, 32'd9, 32'd9);
      repeat (10) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      chk("kill ready next cycle", 64'(ready), 64'd1);
      repeat (40) begin
        if (valid) seen++;
        tick();
      end
      chk("kill no valid", 64'(seen), 64'd0);
      chk("kill result kept", 64'(result), 64'h80000000);
    end

    // Start while busy is ignored and does not disturb the latched operands.
    launch(3'b101, 32'd100, 32'd7);
    tick();
    tick();
    start  = 1'b1;
    funct3 = 3'b000;
    a      = 32'd1234;
    b      = 32'd5678;
    tick();
    start  = 1'b0;
    await_op(32'd14, 1'b0, "start while busy", 3);
    tick();

    // Back-to-back: second start issued in the first op's valid cycle.
    launch(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    await_op(32'hFFFFFFFE, 1'b0, "b2b first", 0);
    launch(3'b110, 32'hFFFFFFF9, 32'd2);
    chk("b2b second accepted", 64'(busy), 64'd1);
    await_op(32'hFFFFFFFF, 1'b0, "b2b second", 0);
    tick();

    // Asynchronous reset mid-calculation.
    begin
      int seen;
      seen = 0;
      launch(3'b000, 32'd11, 32'd13);
      repeat (5) tick();
      #2;
      reset = 1'b0;
      #1;
      chk("mid reset ready", 64'(ready), 64'd1);
      chk("mid reset busy", 64'(busy), 64'd0);
      chk("mid reset valid", 64'(valid), 64'd0);
      chk("mid reset result", 64'(result), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) begin
        tick();
        if (valid) seen++;
      end
      chk("mid reset no stray valid", 64'(seen), 64'd0);
      chk("mid reset result stays", 64'(result), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
